data_inf_rr_arbiter: RTL

- Round-robin, packet-locked arbiter that shares one downstream valid/ready/last data_inf stream among NUM upstream requesters.
- A grant is held from the first beat of a packet through its last beat, so packets never interleave.
- One registered output pipe stage with force-load semantics: the stage loads when empty or when it is being drained.
- Sits in front of shared sinks: DMA write port, FIFO, serializer.

---
 rtl/data_inf_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/data_inf_rr_arbiter.sv
// Round-robin, packet-locked arbiter merging NUM valid/ready/last streams into one registered output.
// Optional watchdog (forced release of a stalled lock, err_timeout pulse): define DATA_INF_ARB_WATCHDOG_EN.
module data_inf_rr_arbiter #(
    parameter int NUM     = 4,
    parameter int DSIZE   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM*DSIZE-1:0]   s_data,
    input  logic [NUM-1:0]         s_valid,
    input  logic [NUM-1:0]         s_last,
    output logic [NUM-1:0]         s_ready,
    output logic [DSIZE-1:0]       m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [NUM-1:0]         curr_grant,
    output logic                   locked
`ifdef DATA_INF_ARB_WATCHDOG_EN
    ,
    output logic                   err_timeout
`endif
);

    localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t           state, state_next;
    logic [PW-1:0]    ptr, ptr_next;
    logic [PW-1:0]    gidx, gidx_next;
    logic [PW-1:0]    pick, cand;
    logic [NUM-1:0]   grant_next;
    logic             any_req;
    logic             load, hs, hs_last;
    logic             g_valid, g_last;
    logic [DSIZE-1:0] g_data;
    logic             wd_fire;

    assign locked  = (state == LOCK);
    assign load    = m_ready || !m_valid;
    assign g_valid = |(s_valid & curr_grant);
    assign g_last  = |(s_last & curr_grant);
    // The only input-to-output combinational path: s_ready follows m_ready.
    assign s_ready = (locked && load) ? curr_grant : '0;
    assign hs      = locked && load && g_valid;
    assign hs_last = hs && g_last;

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NUM; i++) begin
            if (curr_grant[i]) g_data = s_data[i*DSIZE +: DSIZE];
        end
    end

    // Search ptr+1, ptr+2, ... so the lane after the last winner has top priority.
    always_comb begin
        pick    = ptr;
        cand    = ptr;
        any_req = 1'b0;
        for (int k = 1; k <= NUM; k++) begin
            cand = PW'((int'(ptr) + k) % NUM);
            if (!any_req && s_valid[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

`ifdef DATA_INF_ARB_WATCHDOG_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wd_cnt;

    assign wd_fire = locked && !g_valid && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_fire;
            if (!locked || hs) wd_cnt <= '0;
            else if (!g_valid) wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gidx_next  = gidx;
        grant_next = curr_grant;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = LOCK;
                    gidx_next  = pick;
                    grant_next = NUM'(1) << pick;
                end
            end
            LOCK: begin
                if (hs_last || wd_fire) begin
                    state_next = IDLE;
                    ptr_next   = gidx;
                    grant_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= PW'(NUM - 1);
            gidx       <= '0;
            curr_grant <= '0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            gidx       <= gidx_next;
            curr_grant <= grant_next;
        end
    end

    // NOTE: the data register is reset too, so a reset mid-packet leaves no stale beat visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (hs) begin
            m_valid <= 1'b1;
            m_data  <= g_data;
            m_last  <= g_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
